// File: rtl/dfu_boot_ctrl.sv
// Button debouncer, short/long press classifier and warm-boot sequencer for the iCE40 SoC.
// A button release or a software edge selects an image; wb_boot then stays asserted until reset.
module dfu_boot_ctrl #(
   parameter int TIMER_WIDTH = 24,
   parameter int BTN_MODE    = 3,
   parameter int DFU_MODE    = 0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       boot_now,
   input  logic [1:0] boot_sel,
   input  logic       btn_pad,
   output logic       btn_val,
   output logic       rst_req
);

   typedef enum logic [1:0] {
      WB_IDLE  = 2'b00,
      WB_LATCH = 2'b01,
      WB_BOOT  = 2'b10
   } wb_state_t;

   logic                   pressed;
   logic [1:0]             sync_ff;
   logic [1:0]             sync_vld;
   logic                   sync;
   logic [2:0]             integ;
   logic                   btn_q;
   logic                   armed;
   logic [TIMER_WIDTH-1:0] timer;
   logic                   long_press;
   logic                   boot_now_q;
   logic                   sw_edge;
   logic                   release_ev;
   wb_state_t              state;
   wb_state_t              state_next;
   logic [1:0]             wb_sel;
   logic [1:0]             sel_next;
   logic                   wb_boot;
   logic                   rreq_next;

   generate
      if (BTN_MODE == 0) begin : g_nobtn
         logic unused_pad;
         assign pressed    = 1'b0;
         assign unused_pad = btn_pad;
      end else if (BTN_MODE == 1) begin : g_high
         assign pressed = btn_pad;
      end else if (BTN_MODE == 2) begin : g_low
         assign pressed = ~btn_pad;
      end else begin : g_pullup
         logic pad_in;
`ifdef ICE40_PRIMITIVES
         SB_IO #(
            .PIN_TYPE (6'b000001),
            .PULLUP   (1'b1)
         ) u_btn_io (
            .PACKAGE_PIN (btn_pad),
            .D_IN_0      (pad_in)
         );
`else
         assign pad_in = btn_pad;
`endif
         assign pressed = ~pad_in;
      end
   endgenerate

   assign sync       = sync_ff[1];
   assign long_press = timer[TIMER_WIDTH-1];
   assign sw_edge    = boot_now & ~boot_now_q;
   assign release_ev = btn_q & ~btn_val & armed;

   // Synchroniser, debounce integrator and press timer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_ff    <= 2'b00;
         sync_vld   <= 2'b00;
         integ      <= 3'd0;
         btn_val    <= 1'b0;
         btn_q      <= 1'b0;
         armed      <= 1'b0;
         timer      <= '0;
         boot_now_q <= 1'b0;
      end else begin
         sync_ff    <= {sync_ff[0], pressed};
         sync_vld   <= {sync_vld[0], 1'b1};
         btn_q      <= btn_val;
         boot_now_q <= boot_now;
         // Only a genuinely released button (synchroniser refilled after reset) arms actions.
         armed      <= armed | (sync_vld[1] & ~sync & ~btn_val);
         if (sync && integ != 3'd7) begin
            integ <= integ + 3'd1;
         end else if (!sync && integ != 3'd0) begin
            integ <= integ - 3'd1;
         end else begin
            integ <= integ;
         end
         if (integ == 3'd7) begin
            btn_val <= 1'b1;
         end else if (integ == 3'd0) begin
            btn_val <= 1'b0;
         end else begin
            btn_val <= btn_val;
         end
         if (!btn_val) begin
            timer <= '0;
         end else if (!long_press) begin
            timer <= timer + TIMER_WIDTH'(1);
         end else begin
            timer <= timer;
         end
      end
   end

   // Warm-boot sequencer state and its registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= WB_IDLE;
         wb_sel  <= 2'b00;
         wb_boot <= 1'b0;
         rst_req <= 1'b0;
      end else begin
         state   <= state_next;
         wb_sel  <= sel_next;
         wb_boot <= (state_next == WB_BOOT);
         rst_req <= rreq_next;
      end
   end

   // Request arbitration: a software edge beats a simultaneous button release.
   always_comb begin
      state_next = state;
      sel_next   = wb_sel;
      rreq_next  = 1'b0;
      case (state)
         WB_IDLE: begin
            if (sw_edge) begin
               sel_next   = boot_sel;
               state_next = WB_LATCH;
            end else if (release_ev) begin
               if (DFU_MODE == 0) begin
                  if (long_press) begin
                     sel_next   = 2'b01;
                     state_next = WB_LATCH;
                  end else begin
                     rreq_next = 1'b1;
                  end
               end else begin
                  if (!long_press) begin
                     sel_next   = 2'b10;
                     state_next = WB_LATCH;
                  end else begin
                     state_next = WB_IDLE;
                  end
               end
            end else begin
               state_next = WB_IDLE;
            end
         end
         WB_LATCH: state_next = WB_BOOT;
         WB_BOOT:  state_next = WB_BOOT;
         default:  state_next = WB_IDLE;
      endcase
   end

`ifdef ICE40_PRIMITIVES
   SB_WARMBOOT u_warmboot (
      .BOOT (wb_boot),
      .S1   (wb_sel[1]),
      .S0   (wb_sel[0])
   );
`else
   logic unused_wb;
   assign unused_wb = ^{wb_boot, wb_sel};
`endif

endmodule

// File: tb/tb_dfu_boot_ctrl.sv
// Bench for dfu_boot_ctrl: an application-mode and a DFU-mode instance run against a
// press-level reference model under directed and random button / software stimulus.
module tb_dfu_boot_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       boot_now;
   logic [1:0] boot_sel;
   logic       pad0, pad1;
   logic       bv0, rr0, bv1, rr1;

   int checks = 0;
   int errors = 0;

   // reference model state, index 0 = application mode, 1 = DFU mode
   int m_hist0[2], m_hist1[2], m_lvl[2], m_val[2], m_prev[2], m_held[2];
   int m_arm[2], m_sel[2], m_pend[2], m_boot[2], m_rreq[2];
   int m_since, m_bnp;
   int rq_cnt0, seen_bv0;
   logic       bn_r;
   logic [1:0] bs_r;

   always #5 clk = ~clk;

   dfu_boot_ctrl #(.TIMER_WIDTH(6), .BTN_MODE(2), .DFU_MODE(0)) dut0 (
      .clk(clk), .rst(rst), .boot_now(boot_now), .boot_sel(boot_sel),
      .btn_pad(pad0), .btn_val(bv0), .rst_req(rr0));

   dfu_boot_ctrl #(.TIMER_WIDTH(6), .BTN_MODE(2), .DFU_MODE(1)) dut1 (
      .clk(clk), .rst(rst), .boot_now(boot_now), .boot_sel(boot_sel),
      .btn_pad(pad1), .btn_val(bv1), .rst_req(rr1));

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_edge(input logic r, input logic p0, input logic p1,
                             input logic bn, input logic [1:0] bs);
      int sw, pr, sync, lng, rel;
      int n_lvl, n_val, n_held, n_arm, n_sel, n_pend, n_boot, n_rreq;
      if (r) begin
         for (int d = 0; d < 2; d++) begin
            m_hist0[d] = 0; m_hist1[d] = 0; m_lvl[d] = 0; m_val[d] = 0; m_prev[d] = 0;
            m_held[d] = 0; m_arm[d] = 0; m_sel[d] = 0; m_pend[d] = 0; m_boot[d] = 0;
            m_rreq[d] = 0;
         end
         m_since = 0;
         m_bnp   = 0;
         return;
      end
      sw = (bn && !m_bnp) ? 1 : 0;
      for (int d = 0; d < 2; d++) begin
         pr     = (d == 0) ? int'(!p0) : int'(!p1);
         sync   = m_hist1[d];
         n_lvl  = sync ? ((m_lvl[d] < 7) ? m_lvl[d] + 1 : 7) : ((m_lvl[d] > 0) ? m_lvl[d] - 1 : 0);
         n_val  = (m_lvl[d] == 7) ? 1 : ((m_lvl[d] == 0) ? 0 : m_val[d]);
         n_held = m_val[d] ? ((m_held[d] < 32) ? m_held[d] + 1 : 32) : 0;
         n_arm  = (m_arm[d] || (m_since >= 2 && !sync && !m_val[d])) ? 1 : 0;
         rel    = (m_prev[d] && !m_val[d] && m_arm[d]) ? 1 : 0;
         lng    = (m_held[d] >= 32) ? 1 : 0;
         n_rreq = 0;
         n_sel  = m_sel[d];
         n_pend = m_pend[d];
         n_boot = (m_boot[d] || m_pend[d]) ? 1 : 0;
         if (!m_pend[d] && !m_boot[d]) begin
            if (sw) begin
               n_sel = bs; n_pend = 1;
            end else if (rel && d == 0) begin
               if (lng) begin n_sel = 1; n_pend = 1; end
               else n_rreq = 1;
            end else if (rel && d == 1 && !lng) begin
               n_sel = 2; n_pend = 1;
            end
         end
         m_hist1[d] = m_hist0[d];
         m_hist0[d] = pr;
         m_prev[d]  = m_val[d];
         m_lvl[d]   = n_lvl;  m_val[d]  = n_val;  m_held[d] = n_held; m_arm[d] = n_arm;
         m_sel[d]   = n_sel;  m_pend[d] = n_pend; m_boot[d] = n_boot; m_rreq[d] = n_rreq;
      end
      m_bnp = bn;
      if (m_since < 100) m_since++;
   endtask

   task automatic step(input logic r, input logic p0, input logic p1,
                       input logic bn, input logic [1:0] bs);
      @(negedge clk);
      rst = r; pad0 = p0; pad1 = p1; boot_now = bn; boot_sel = bs;
      @(posedge clk);
      model_edge(r, p0, p1, bn, bs);
      #1;
      check_val("btn_val0", bv0, m_val[0]);
      check_val("rst_req0", rr0, m_rreq[0]);
      check_val("wb_sel0", dut0.wb_sel, m_sel[0]);
      check_val("wb_boot0", dut0.wb_boot, m_boot[0]);
      check_val("btn_val1", bv1, m_val[1]);
      check_val("rst_req1", rr1, m_rreq[1]);
      check_val("wb_sel1", dut1.wb_sel, m_sel[1]);
      check_val("wb_boot1", dut1.wb_boot, m_boot[1]);
      rq_cnt0  += int'(rr0);
      seen_bv0 |= int'(bv0);
   endtask

   task automatic hold(input int n, input logic p);
      for (int i = 0; i < n; i++) step(1'b0, p, p, 1'b0, 2'b00);
   endtask

   task automatic do_reset(input logic p);
      for (int i = 0; i < 3; i++) step(1'b1, p, p, 1'b0, 2'b00);
      rq_cnt0  = 0;
      seen_bv0 = 0;
   endtask

   initial begin
      rst = 1'b1; pad0 = 1'b1; pad1 = 1'b1; boot_now = 1'b0; boot_sel = 2'b00;
      bn_r = 1'b0; bs_r = 2'b00;
      model_edge(1'b1, 1'b1, 1'b1, 1'b0, 2'b00);

      do_reset(1'b1);
      check_val("rst_btn_val", bv0, 0);
      check_val("rst_rst_req", rr0, 0);
      check_val("rst_wb_boot", dut0.wb_boot, 0);
      check_val("rst_wb_sel", dut0.wb_sel, 0);
      hold(5, 1'b1);

      // glitch too short to register
      hold(3, 1'b0); hold(15, 1'b1);
      check_val("glitch_btn_seen", seen_bv0, 0);
      check_val("glitch_rst_req", rq_cnt0, 0);

      // short press: one reset pulse in app mode, image 2 in DFU mode
      hold(20, 1'b0); hold(20, 1'b1);
      check_val("short_btn_seen", seen_bv0, 1);
      check_val("short_rst_req_cnt", rq_cnt0, 1);
      check_val("short_wb_boot0", dut0.wb_boot, 0);
      check_val("short_wb_sel1", dut1.wb_sel, 2);
      check_val("short_wb_boot1", dut1.wb_boot, 1);

      // long press: image 1 in app mode, nothing in DFU mode
      do_reset(1'b1); hold(3, 1'b1);
      hold(60, 1'b0); hold(20, 1'b1);
      check_val("long_wb_sel0", dut0.wb_sel, 1);
      check_val("long_wb_boot0", dut0.wb_boot, 1);
      check_val("long_rst_req_cnt", rq_cnt0, 0);
      check_val("long_wb_boot1", dut1.wb_boot, 0);

      // software request held high: latch, then boot one cycle later, single trigger
      do_reset(1'b1); hold(3, 1'b1);
      step(1'b0, 1'b1, 1'b1, 1'b1, 2'b11);
      check_val("sw_latch_sel", dut0.wb_sel, 3);
      check_val("sw_latch_boot", dut0.wb_boot, 0);
      step(1'b0, 1'b1, 1'b1, 1'b1, 2'b11);
      check_val("sw_boot", dut0.wb_boot, 1);
      for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b1, 1'b1, 2'b00);
      check_val("sw_sel_frozen", dut1.wb_sel, 3);

      // button held through reset release is ignored
      do_reset(1'b0);
      hold(40, 1'b0); hold(20, 1'b1);
      check_val("held_rst_req_cnt", rq_cnt0, 0);
      check_val("held_wb_boot0", dut0.wb_boot, 0);
      check_val("held_wb_boot1", dut1.wb_boot, 0);

      // random presses, bounces, resets and software requests
      do_reset(1'b1);
      for (int seg = 0; seg < 150; seg++) begin
         int len, nb;
         logic p1d;
         if ($urandom_range(0, 5) == 0) do_reset(1'($urandom_range(0, 1)));
         case ($urandom_range(0, 2))
            0:       len = $urandom_range(1, 6);
            1:       len = $urandom_range(8, 28);
            default: len = $urandom_range(34, 80);
         endcase
         nb  = $urandom_range(0, 4);
         p1d = ($urandom_range(0, 5) == 0);
         for (int i = 0; i < nb + len + 25; i++) begin
            logic p, r;
            if (i < nb)            p = 1'($urandom_range(0, 1));
            else if (i < nb + len) p = 1'b0;
            else                   p = 1'b1;
            r = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 59) == 0) bn_r = ~bn_r;
            if (!bn_r) bs_r = 2'($urandom_range(0, 3));
            step(r, p, p ^ (p1d & (i[2:0] == 3'd0)), bn_r, bs_r);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
